fsm_burst_arb: RTL

Arbiter and sequencer that shares one instance of the 2-bit-input / 2-bit-output sequential detector FSM between two symbol-stream requesters (A, B). Each grant gives one requester a burst: the FSM is first cleared to state A, then the requester's symbols are driven onto the FSM X input one per cycle, and the FSM Z output is returned, tagged with the requester id. The block sits between stimulus sources and the detector and owns the detector's reset line.

---
 rtl/fsm_burst_arb_pkg.sv | 27 ++
 rtl/fsm_burst_arb_rr.sv | 37 +++
 rtl/fsm_burst_arb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fsm_burst_arb_pkg.sv
// Shared types and constants for the burst arbiter in front of the 2-bit symbol detector.
package fsm_burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic ID_A  = 1'b0;
  localparam logic ID_B  = 1'b1;
  localparam int   SYM_W = 2;

  // Lone requester wins; on a tie the one not served last wins.
  function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last_served);
    logic pick;
    if (req_a && req_b) begin
      pick = ~last_served;
    end else if (req_a) begin
      pick = ID_A;
    end else begin
      pick = ID_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/fsm_burst_arb_rr.sv
// Two-requester round-robin pick plus the last_served register, updated by a serve strobe.
module rr_arb2
  import fsm_burst_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic serve,
  input  logic serve_id,
  output logic winner
);

  logic last_served_q;
  logic last_served_d;

  always_comb begin
    last_served_d = last_served_q;
    if (serve) begin
      last_served_d = serve_id;
    end else begin
      last_served_d = last_served_q;
    end
  end

  // B counts as served last out of reset so A takes the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_served_q <= ID_B;
    end else begin
      last_served_q <= last_served_d;
    end
  end

  assign winner = rr_pick(req_a, req_b, last_served_q);

endmodule

// File: rtl/fsm_burst_arb.sv
// Shares one 2-bit detector FSM between requesters A and B in bursts, owning its reset line.
// Optional per-requester burst counters are built when SYM_ARB_STATS_EN is defined.
module fsm_burst_arb
  import fsm_burst_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
`ifdef SYM_ARB_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [SYM_W-1:0] a_sym,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [SYM_W-1:0] b_sym,
  input  logic             b_last,
  output logic             b_ready,
  output logic [SYM_W-1:0] fsm_x,
  output logic             fsm_rst,
  input  logic [1:0]       fsm_z,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [1:0]       resp_z,
  output logic             resp_last,
  output logic             resp_trunc,
  output logic             abort,
  output logic             busy
`ifdef SYM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] a_bursts,
  output logic [CNT_W-1:0] b_bursts
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic [3:0] cnt_q, cnt_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic [1:0] resp_z_q, resp_z_d;
  logic       resp_last_q, resp_last_d;
  logic       resp_trunc_q, resp_trunc_d;
  logic       abort_q, abort_d;

  logic             winner_s;
  logic             serve_s;
  logic             g_valid_s;
  logic             g_last_s;
  logic [SYM_W-1:0] g_sym_s;
  logic [3:0]       cnt_inc_s;

  rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_a    (a_valid),
    .req_b    (b_valid),
    .serve    (serve_s),
    .serve_id (grant_q),
    .winner   (winner_s)
  );

  assign g_valid_s = (grant_q == ID_B) ? b_valid : a_valid;
  assign g_last_s  = (grant_q == ID_B) ? b_last  : a_last;
  assign g_sym_s   = (grant_q == ID_B) ? b_sym   : a_sym;
  assign cnt_inc_s = cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_id_d    = grant_q;
    resp_z_d     = 2'b00;
    resp_last_d  = 1'b0;
    resp_trunc_d = 1'b0;
    abort_d      = 1'b0;
    serve_s      = 1'b0;
    fsm_rst      = 1'b1;
    fsm_x        = '0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid || b_valid) begin
          grant_d = winner_s;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d   = 4'd0;
        state_d = RUN;
      end
      RUN: begin
        fsm_rst = 1'b0;
        a_ready = (grant_q == ID_A);
        b_ready = (grant_q == ID_B);
        if (g_valid_s) begin
          fsm_x        = g_sym_s;
          resp_valid_d = 1'b1;
          resp_z_d     = fsm_z;
          cnt_d        = cnt_inc_s;
          // last wins over truncation when both land on the same symbol
          if (g_last_s) begin
            resp_last_d = 1'b1;
            serve_s     = 1'b1;
            state_d     = IDLE;
          end else if (cnt_inc_s == MAX_B) begin
            resp_last_d  = 1'b1;
            resp_trunc_d = 1'b1;
            serve_s      = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = RUN;
          end
        end else begin
          // No hold symbol exists for the detector, so the burst is void.
          abort_d = 1'b1;
          serve_s = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= ID_A;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_z_q     <= 2'b00;
      resp_last_q  <= 1'b0;
      resp_trunc_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_z_q     <= resp_z_d;
      resp_last_q  <= resp_last_d;
      resp_trunc_q <= resp_trunc_d;
      abort_q      <= abort_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_z     = resp_z_q;
  assign resp_last  = resp_last_q;
  assign resp_trunc = resp_trunc_q;
  assign abort      = abort_q;
  assign busy       = (state_q != IDLE);

`ifdef SYM_ARB_STATS_EN
  logic [CNT_W-1:0] a_bursts_q, a_bursts_d;
  logic [CNT_W-1:0] b_bursts_q, b_bursts_d;

  // Completed bursts only; aborts never raise resp_last.
  always_comb begin
    a_bursts_d = a_bursts_q;
    b_bursts_d = b_bursts_q;
    if (resp_last_d && (resp_id_d == ID_A) && (a_bursts_q != '1)) begin
      a_bursts_d = a_bursts_q + CNT_W'(1);
    end else if (resp_last_d && (resp_id_d == ID_B) && (b_bursts_q != '1)) begin
      b_bursts_d = b_bursts_q + CNT_W'(1);
    end else begin
      a_bursts_d = a_bursts_q;
      b_bursts_d = b_bursts_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_bursts_q <= '0;
      b_bursts_q <= '0;
    end else begin
      a_bursts_q <= a_bursts_d;
      b_bursts_q <= b_bursts_d;
    end
  end

  assign a_bursts = a_bursts_q;
  assign b_bursts = b_bursts_q;
`endif

endmodule
